alu_scheduler: RTL and testbench

- Multi-cycle controller that shares one combinational ALU between two requesters (e.g. fetch-side PC adder and execute stage).
- Round-robin arbitration with valid/ready handshakes on both sides.
- Sequences the 3-step multiply (MUL, then read LO, then read HI) so a requester gets a full 2N-bit product in one response.
- Sits between the pipeline/control units and the ALU; the ALU's ports connect to alu_in0/alu_in1/alu_op/alu_out.

---
 rtl/alu_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_alu_scheduler.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Shares one combinational ALU between two requesters. Arbitration is
//   round-robin. A 3-step multiply (MUL, read LO, read HI) is sequenced
//   internally so that one response carries the full 2N-bit product.
//   Only one operation is in flight at a time.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   req{0,1}_valid/ready       request handshake; ready is combinational
//                              and only asserted in IDLE for the granted side
//   req{0,1}_op/a/b            opcode and operands, captured on handshake
//   alu_in0/alu_in1/alu_op     drive the shared ALU (all zero while idle)
//   alu_out                    ALU result, combinational from the above
//   rsp_valid/ready            response handshake
//   rsp_id                     requester owning the response
//   rsp_lo/rsp_hi              result (hi = 0 for non-MUL ops)
//   rsp_zero                   rsp_lo == 0
//   busy                       high whenever not in IDLE
module alu_scheduler #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [3:0]   req0_op,
  input  logic [N-1:0] req0_a,
  input  logic [N-1:0] req0_b,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [3:0]   req1_op,
  input  logic [N-1:0] req1_a,
  input  logic [N-1:0] req1_b,
  output logic [N-1:0] alu_in0,
  output logic [N-1:0] alu_in1,
  output logic [3:0]   alu_op,
  input  logic [N-1:0] alu_out,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [N-1:0] rsp_lo,
  output logic [N-1:0] rsp_hi,
  output logic         rsp_zero,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    MUL,
    RDLO,
    RDHI,
    RESP
  } state_t;

  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_MFLO = 4'b0110;
  localparam logic [3:0] OP_MFHI = 4'b0111;

  state_t       state;
  state_t       state_nx;

  logic         last_grant;
  logic         grant_id;
  logic         take;
  logic [3:0]   sel_op;
  logic [N-1:0] sel_a;
  logic [N-1:0] sel_b;

  logic [3:0]   op_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         id_q;
  logic [N-1:0] lo_q;
  logic [N-1:0] hi_q;

  // With a single valid requester it wins outright; on a tie the side that
  // did not win last time is chosen. When neither is valid grant_id is 0,
  // which is harmless because ready is also qualified by valid.
  always_comb begin
    grant_id = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    sel_op   = grant_id ? req1_op : req0_op;
    sel_a    = grant_id ? req1_a  : req0_a;
    sel_b    = grant_id ? req1_b  : req0_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    take       = 1'b0;
    alu_op     = '0;
    alu_in0    = '0;
    alu_in1    = '0;
    case (state)
      IDLE: begin
        req0_ready = req0_valid & ~grant_id;
        req1_ready = req1_valid &  grant_id;
        take       = req0_ready | req1_ready;
        if (take) begin
          state_nx = (sel_op == OP_MUL) ? MUL : EXEC;
        end
      end
      EXEC: begin
        alu_op   = op_q;
        alu_in0  = a_q;
        alu_in1  = b_q;
        state_nx = RESP;
      end
      MUL: begin
        alu_op   = OP_MUL;
        alu_in0  = a_q;
        alu_in1  = b_q;
        state_nx = RDLO;
      end
      RDLO: begin
        alu_op   = OP_MFLO;
        alu_in0  = a_q;
        alu_in1  = b_q;
        state_nx = RDHI;
      end
      RDHI: begin
        alu_op   = OP_MFHI;
        alu_in0  = a_q;
        alu_in1  = b_q;
        state_nx = RESP;
      end
      RESP: begin
        // No accept in the cycle the response is consumed: IDLE follows.
        if (rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      id_q       <= 1'b0;
      lo_q       <= '0;
      hi_q       <= '0;
    end else begin
      if (take) begin
        op_q       <= sel_op;
        a_q        <= sel_a;
        b_q        <= sel_b;
        id_q       <= grant_id;
        last_grant <= grant_id;
      end
      case (state)
        EXEC: begin
          lo_q <= alu_out;
          hi_q <= '0;
        end
        RDLO: lo_q <= alu_out;
        RDHI: hi_q <= alu_out;
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign rsp_id    = id_q;
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_zero  = (lo_q == '0);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_alu_scheduler.sv
`timescale 1ns/1ps
module tb_alu_scheduler;
  localparam int N = 32;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_MUL  = 4'd5;
  localparam logic [3:0] OP_MFLO = 4'd6;
  localparam logic [3:0] OP_MFHI = 4'd7;
  localparam logic [3:0] OP_SLT  = 4'd8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [3:0]   req0_op = '0, req1_op = '0;
  logic [N-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [N-1:0] alu_in0, alu_in1, alu_out;
  logic [3:0]   alu_op;
  logic         rsp_valid, rsp_ready = 1'b0, rsp_id, rsp_zero, busy;
  logic [N-1:0] rsp_lo, rsp_hi;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_scheduler #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_zero(rsp_zero), .busy(busy)
  );

  // Environment ALU: combinational result, hi/lo product registers loaded on MUL.
  logic [N-1:0] alu_hi = '0, alu_lo = '0;

  function automatic logic [N-1:0] alu_f(input logic [3:0] op, input logic [N-1:0] a, b, hi, lo);
    logic [2*N-1:0] p;
    p = {{N{1'b0}}, a} * {{N{1'b0}}, b};
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_MUL:  return p[N-1:0];
      OP_MFLO: return lo;
      OP_MFHI: return hi;
      OP_SLT:  return (a < b) ? N'(1) : N'(0);
      default: return ~a;
    endcase
  endfunction

  assign alu_out = alu_f(alu_op, alu_in0, alu_in1, alu_hi, alu_lo);

  always @(posedge clk) begin
    if (alu_op == OP_MUL) {alu_hi, alu_lo} <= {{N{1'b0}}, alu_in0} * {{N{1'b0}}, alu_in1};
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit id, input logic v, input logic [3:0] op, input logic [N-1:0] a, b);
    if (id) begin
      req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
    end else begin
      req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
    end
  endtask

  function automatic logic rdy(input bit id);
    return id ? req1_ready : req0_ready;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    #1;
    while (busy && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check(nm, 64'(busy), 64'(0));
  endtask

  // One request with rsp_ready high; checks grant, latency and the response.
  task automatic txn(input bit id, input logic [3:0] op, input logic [N-1:0] a, b,
                     input logic [N-1:0] elo, ehi, input string nm);
    int n;
    int lat;
    rsp_ready = 1'b1;
    set_req(id, 1, op, a, b);
    #1;
    n = 0;
    while (!rdy(id) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, " ready"}, 64'(rdy(id)), 64'(1));
    @(negedge clk);
    set_req(id, 0, '0, '0, '0);
    #1;
    lat = 1;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk); #1; lat++;
    end
    check({nm, " latency"}, 64'(lat), 64'((op == OP_MUL) ? 4 : 2));
    check({nm, " rsp_id"}, 64'(rsp_id), 64'(id));
    check({nm, " rsp_lo"}, 64'(rsp_lo), 64'(elo));
    check({nm, " rsp_hi"}, 64'(rsp_hi), 64'(ehi));
    check({nm, " rsp_zero"}, 64'(rsp_zero), 64'(elo == '0));
    @(negedge clk); #1;
    check({nm, " idle after rsp"}, 64'(busy), 64'(0));
  endtask

  typedef struct {
    bit           id;
    logic [3:0]   op;
    logic [N-1:0] a, b, lo, hi;
  } vec_t;

  vec_t tbl [12];

  // Random-phase reference model state
  bit           mlast, mbusy, acc0, acc1, g, e0, e1, erv, eid;
  int           cnt, elat;
  logic [N-1:0] mhi, mlo, elo, ehi;
  logic [2*N-1:0] p;

  task automatic draw(input bit id);
    logic [N-1:0] a;
    logic [N-1:0] b;
    a = ($urandom % 4 == 0) ? N'($urandom % 8) : N'($urandom);
    b = ($urandom % 4 == 0) ? a : N'($urandom);
    set_req(id, ($urandom % 3) != 0, 4'($urandom_range(0, 15)), a, b);
  endtask

  initial begin
    int n, ng;
    bit expg;

    // ---- reset values
    #1;
    check("rst rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst rsp_id", 64'(rsp_id), 64'(0));
    check("rst rsp_lo", 64'(rsp_lo), 64'(0));
    check("rst rsp_hi", 64'(rsp_hi), 64'(0));
    check("rst rsp_zero", 64'(rsp_zero), 64'(1));
    check("rst busy", 64'(busy), 64'(0));
    check("rst req0_ready", 64'(req0_ready), 64'(0));
    check("rst req1_ready", 64'(req1_ready), 64'(0));
    check("rst alu_op", 64'(alu_op), 64'(0));
    check("rst alu_in0", 64'(alu_in0), 64'(0));
    check("rst alu_in1", 64'(alu_in1), 64'(0));
    do_reset();

    // ---- directed table (ALU hi/lo state carries from entry to entry)
    tbl[0]  = '{1'b0, OP_ADD,  32'd5, 32'd7, 32'd12, 32'd0};
    tbl[1]  = '{1'b1, OP_SUB,  32'd9, 32'd9, 32'd0, 32'd0};
    tbl[2]  = '{1'b0, OP_OR,   32'd3, 32'd4, 32'd7, 32'd0};
    tbl[3]  = '{1'b1, OP_MUL,  32'h0001_0000, 32'h0001_0000, 32'h0, 32'h1};
    tbl[4]  = '{1'b0, OP_MFHI, 32'd0, 32'd0, 32'd1, 32'd0};
    tbl[5]  = '{1'b0, OP_MFLO, 32'd0, 32'd0, 32'd0, 32'd0};
    tbl[6]  = '{1'b1, OP_MUL,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE};
    tbl[7]  = '{1'b0, OP_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd0};
    tbl[8]  = '{1'b1, OP_SLT,  32'd3, 32'd5, 32'd1, 32'd0};
    tbl[9]  = '{1'b0, OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 32'd0};
    tbl[10] = '{1'b1, OP_AND,  32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 32'd0};
    tbl[11] = '{1'b0, 4'b1111, 32'd0, 32'd9, 32'hFFFF_FFFF, 32'd0};
    for (int i = 0; i < 12; i++) begin
      txn(tbl[i].id, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lo, tbl[i].hi, $sformatf("vec%0d", i));
    end

    // ---- MUL step sequence on the ALU port
    rsp_ready = 1'b1;
    set_req(1, 1, OP_MUL, 32'h0001_0000, 32'h0001_0000);
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("mulseq ready", 64'(req1_ready), 64'(1));
    check("mulseq idle op", 64'(alu_op), 64'(0));
    @(negedge clk); set_req(1, 0, '0, '0, '0); #1;
    check("mulseq op1", 64'(alu_op), 64'(OP_MUL));
    @(negedge clk); #1;
    check("mulseq op2", 64'(alu_op), 64'(OP_MFLO));
    check("mulseq in0", 64'(alu_in0), 64'(32'h0001_0000));
    check("mulseq in1", 64'(alu_in1), 64'(32'h0001_0000));
    @(negedge clk); #1;
    check("mulseq op3", 64'(alu_op), 64'(OP_MFHI));
    check("mulseq early valid", 64'(rsp_valid), 64'(0));
    @(negedge clk); #1;
    check("mulseq valid", 64'(rsp_valid), 64'(1));
    check("mulseq lo", 64'(rsp_lo), 64'(0));
    check("mulseq hi", 64'(rsp_hi), 64'(1));
    check("mulseq id", 64'(rsp_id), 64'(1));
    wait_idle("mulseq drain");

    // ---- backpressure: response held 5 cycles, other requester waits
    rsp_ready = 1'b0;
    set_req(0, 1, OP_ADD, 32'd1, 32'd2);
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("bp ready", 64'(req0_ready), 64'(1));
    @(negedge clk);
    set_req(0, 0, '0, '0, '0);
    set_req(1, 1, OP_OR, 32'd8, 32'd1);
    #1;
    n = 0;
    while (!rsp_valid && n < 10) begin
      @(negedge clk); #1; n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp rsp_valid", 64'(rsp_valid), 64'(1));
      check("bp rsp_lo", 64'(rsp_lo), 64'(3));
      check("bp rsp_hi", 64'(rsp_hi), 64'(0));
      check("bp rsp_id", 64'(rsp_id), 64'(0));
      check("bp rsp_zero", 64'(rsp_zero), 64'(0));
      check("bp req0_ready", 64'(req0_ready), 64'(0));
      check("bp req1_ready", 64'(req1_ready), 64'(0));
      @(negedge clk);
      if (k == 4) rsp_ready = 1'b1;
      #1;
    end
    check("bp still valid", 64'(rsp_valid), 64'(1));
    check("bp no accept in resp", 64'(req1_ready), 64'(0));
    @(negedge clk); #1;
    check("bp idle", 64'(busy), 64'(0));
    check("bp valid dropped", 64'(rsp_valid), 64'(0));
    check("bp req1 now ready", 64'(req1_ready), 64'(1));
    set_req(1, 0, '0, '0, '0);

    // ---- reset while in RDLO
    set_req(1, 1, OP_MUL, 32'd3, 32'd4);
    #1;
    n = 0;
    while (!req1_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("rstmid ready", 64'(req1_ready), 64'(1));
    @(negedge clk); set_req(1, 0, '0, '0, '0);
    @(negedge clk); #1;
    check("rstmid in rdlo", 64'(alu_op), 64'(OP_MFLO));
    #1 rst_n = 1'b0;
    #1;
    check("rstmid busy", 64'(busy), 64'(0));
    check("rstmid rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstmid alu_op", 64'(alu_op), 64'(0));
    check("rstmid alu_in0", 64'(alu_in0), 64'(0));
    check("rstmid alu_in1", 64'(alu_in1), 64'(0));
    check("rstmid rsp_lo", 64'(rsp_lo), 64'(0));
    check("rstmid rsp_hi", 64'(rsp_hi), 64'(0));
    check("rstmid rsp_zero", 64'(rsp_zero), 64'(1));
    check("rstmid rsp_id", 64'(rsp_id), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); #1;
      check("rstmid no rsp", 64'(rsp_valid), 64'(0));
    end
    txn(1, OP_ADD, 32'd10, 32'd20, 32'd30, 32'd0, "post-reset");

    // ---- tie arbitration: both continuously valid, six grants
    do_reset();
    rsp_ready = 1'b1;
    set_req(0, 1, OP_ADD, 32'd1, 32'd1);
    set_req(1, 1, OP_ADD, 32'd2, 32'd2);
    ng = 0; n = 0; expg = 1'b0;
    while (ng < 6 && n < 60) begin
      #1;
      if (!busy) check("tie idle alu_op", 64'(alu_op), 64'(0));
      if (req0_ready || req1_ready) begin
        check("tie single ready", 64'(req0_ready & req1_ready), 64'(0));
        check("tie grant", 64'(req1_ready), 64'(expg));
        expg = !expg;
        ng++;
      end
      @(negedge clk);
      n++;
    end
    check("tie grant count", 64'(ng), 64'(6));
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    wait_idle("tie drain");

    // ---- randomized traffic against a transaction-level model
    do_reset();
    mlast = 1'b1; mbusy = 1'b0; cnt = 0; elat = 0;
    acc0 = 1'b1; acc1 = 1'b1; eid = 1'b0;
    mhi = alu_hi; mlo = alu_lo; elo = '0; ehi = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(negedge clk);
      if (!req0_valid || acc0 || ($urandom % 8 == 0)) draw(0);
      if (!req1_valid || acc1 || ($urandom % 8 == 0)) draw(1);
      rsp_ready = ($urandom % 4) != 0;
      #1;
      g  = (req0_valid && req1_valid) ? !mlast : req1_valid;
      e0 = !mbusy && req0_valid && !g;
      e1 = !mbusy && req1_valid && g;
      acc0 = e0; acc1 = e1;
      check("rnd req0_ready", 64'(req0_ready), 64'(e0));
      check("rnd req1_ready", 64'(req1_ready), 64'(e1));
      check("rnd busy", 64'(busy), 64'(mbusy));
      if (!mbusy) check("rnd idle alu_op", 64'(alu_op), 64'(0));
      erv = mbusy && (cnt >= elat);
      check("rnd rsp_valid", 64'(rsp_valid), 64'(erv));
      if (erv) begin
        check("rnd rsp_id", 64'(rsp_id), 64'(eid));
        check("rnd rsp_lo", 64'(rsp_lo), 64'(elo));
        check("rnd rsp_hi", 64'(rsp_hi), 64'(ehi));
        check("rnd rsp_zero", 64'(rsp_zero), 64'(elo == '0));
      end
      if (mbusy) begin
        if (erv && rsp_ready) mbusy = 1'b0;
        else cnt++;
      end else if (e0 || e1) begin
        if ((g ? req1_op : req0_op) == OP_MUL) begin
          p = g ? {{N{1'b0}}, req1_a} * {{N{1'b0}}, req1_b}
                : {{N{1'b0}}, req0_a} * {{N{1'b0}}, req0_b};
          {mhi, mlo} = p;
          elo = p[N-1:0]; ehi = p[2*N-1:N]; elat = 4;
        end else begin
          elo = g ? alu_f(req1_op, req1_a, req1_b, mhi, mlo)
                  : alu_f(req0_op, req0_a, req0_b, mhi, mlo);
          ehi = '0; elat = 2;
        end
        eid = g; mlast = g; mbusy = 1'b1; cnt = 1;
      end
    end
    @(negedge clk);
    set_req(0, 0, '0, '0, '0);
    set_req(1, 0, '0, '0, '0);
    rsp_ready = 1'b1;
    wait_idle("rnd drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
